pipe_seq_ctrl: RTL

PIPE_SEQ_CTRL -- requirements
Module: pipe_seq_ctrl

---
 rtl/pipe_seq_ctrl.sv | 61 ++++++
 1 files changed

// File: rtl/pipe_seq_ctrl.sv
// pipe_seq_ctrl: pipeline stall/flush sequencer with multi-cycle mul/div handshake and timeout
module pipe_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard_stall_i,
  input  logic        redirect_i,
  input  logic        md_start_i,
  input  logic        md_done_i,
  output logic        pc_we_o,
  output logic        pc_sel_o,
  output logic        ifid_we_o,
  output logic        ifid_flush_o,
  output logic        idex_we_o,
  output logic        idex_flush_o,
  output logic        exme_flush_o,
  output logic        md_req_o,
  output logic        md_err_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);
  localparam logic [1:0] RUN     = 2'b00;
  localparam logic [1:0] MD_BUSY = 2'b01;
  localparam logic [1:0] MD_DONE = 2'b10;
  logic [5:0] busy_cnt;
  logic [1:0] state_nxt;
  logic       freeze, stall, redir, timeout;
  always_comb begin
    freeze       = state_o == MD_BUSY || (state_o == RUN && md_start_i);
    stall        = !freeze && hazard_stall_i;
    redir        = !freeze && !hazard_stall_i && redirect_i;
    pc_we_o      = !rst && !freeze && !stall;
    pc_sel_o     = !rst && redir;
    ifid_we_o    = !rst && !freeze && !stall;
    ifid_flush_o = rst || redir;
    idex_we_o    = !rst && !freeze;
    idex_flush_o = rst || stall;
    exme_flush_o = rst || freeze;
    // 63rd busy cycle without a result: give up and release the pipeline
    timeout      = state_o == MD_BUSY && !md_done_i && busy_cnt == 6'd62;
    state_nxt    = state_o == RUN     ? (md_start_i ? MD_BUSY : RUN) :
                   state_o == MD_BUSY ? ((md_done_i || timeout) ? MD_DONE : MD_BUSY) : RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_o     <= RUN;
      md_req_o    <= 1'b0;
      md_err_o    <= 1'b0;
      busy_cnt    <= 6'd0;
      stall_cnt_o <= 32'd0;
      flush_cnt_o <= 32'd0;
    end else begin
      state_o     <= state_nxt;
      md_req_o    <= state_o == RUN && md_start_i;
      md_err_o    <= md_err_o || timeout;
      busy_cnt    <= state_o == MD_BUSY ? busy_cnt + 6'd1 : 6'd0;
      stall_cnt_o <= stall_cnt_o + {31'd0, !pc_we_o};
      flush_cnt_o <= flush_cnt_o + {31'd0, ifid_flush_o};
    end
  end
endmodule
